pll_loop_ctrl: RTL and testbench

//  Consumes phase_detector output (signed centidegrees + valid strobe) and drives the NCO frequency tuning word.

---
 rtl/pll_pkg.sv | 40 ++++
 rtl/pll_pi_filter.sv | 46 ++++
 rtl/pll_loop_ctrl.sv | 173 +++++++++++++++++
 tb/tb_pll_loop_ctrl.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pll_pkg.sv
// rtl/pll_pkg.sv - shared types, widths, default constants and helpers for the PLL loop controller
package pll_pkg;

   localparam int FTW_W = 32;
   localparam int PH_W  = 16;

   localparam logic [FTW_W-1:0] PLL_SWEEP_START = 32'h28F5C28F;
   localparam logic [FTW_W-1:0] PLL_SWEEP_STOP  = 32'h2B851EB8;
   localparam logic [FTW_W-1:0] PLL_SWEEP_STEP  = 32'h00010000;

   // Phase thresholds in centidegrees
   localparam logic [PH_W-1:0] PLL_CAPTURE_TH = 16'd3000;
   localparam logic [PH_W-1:0] PLL_LOCK_TH    = 16'd500;
   localparam logic [PH_W-1:0] PLL_UNLOCK_TH  = 16'd2000;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_SWEEP   = 2'd1,
      ST_ACQUIRE = 2'd2,
      ST_LOCKED  = 2'd3
   } pll_state_t;

   // Most-negative input folds onto the most-positive magnitude instead of overflowing
   function automatic logic [PH_W-1:0] abs_phase(input logic signed [PH_W-1:0] p);
      if (p == {1'b1, {(PH_W-1){1'b0}}})
         return {1'b0, {(PH_W-1){1'b1}}};
      return (p < 0) ? -p : p;
   endfunction

   function automatic logic [FTW_W-1:0] clamp_ftw(input logic signed [FTW_W+1:0] v,
                                                  input logic [FTW_W-1:0] lo,
                                                  input logic [FTW_W-1:0] hi);
      if (v < $signed({2'b00, lo}))
         return lo;
      if (v > $signed({2'b00, hi}))
         return hi;
      return v[FTW_W-1:0];
   endfunction

endpackage

// File: rtl/pll_pi_filter.sv
// rtl/pll_pi_filter.sv - PI datapath: registered saturating integrator plus combinational tuning word
module pll_pi_filter
   import pll_pkg::*;
#(
   parameter logic [FTW_W-1:0] FTW_MIN  = PLL_SWEEP_START,
   parameter logic [FTW_W-1:0] FTW_MAX  = PLL_SWEEP_STOP,
   parameter int               KP_SHIFT = 4,
   parameter int               KI_SHIFT = 10
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   clear,
   input  logic                   load,
   input  logic [FTW_W-1:0]       load_val,
   input  logic                   update,
   input  logic signed [PH_W-1:0] phase,
   output logic [FTW_W-1:0]       ftw_pi
);

   logic [FTW_W-1:0]        integ;
   logic [FTW_W-1:0]        integ_n;
   logic signed [FTW_W+1:0] phase_ext;
   logic signed [FTW_W+1:0] integ_sum;
   logic signed [FTW_W+1:0] prop_sum;

   // Two guard bits keep the sums exact so saturation never sees a wrapped value
   always_comb begin
      phase_ext = {{(FTW_W+2-PH_W){phase[PH_W-1]}}, phase};
      integ_sum = $signed({2'b00, integ}) + (phase_ext >>> KI_SHIFT);
      integ_n   = clamp_ftw(integ_sum, FTW_MIN, FTW_MAX);
      prop_sum  = $signed({2'b00, integ_n}) + (phase_ext >>> KP_SHIFT);
      ftw_pi    = clamp_ftw(prop_sum, FTW_MIN, FTW_MAX);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         integ <= '0;
      else if (clear)
         integ <= '0;
      else if (load)
         integ <= load_val;
      else if (update)
         integ <= integ_n;
   end

endmodule

// File: rtl/pll_loop_ctrl.sv
// rtl/pll_loop_ctrl.sv - sweep / capture / PI-track controller driving the NCO tuning word
module pll_loop_ctrl
   import pll_pkg::*;
#(
   parameter logic [FTW_W-1:0] SWEEP_START = PLL_SWEEP_START,
   parameter logic [FTW_W-1:0] SWEEP_STOP  = PLL_SWEEP_STOP,
   parameter logic [FTW_W-1:0] SWEEP_STEP  = PLL_SWEEP_STEP,
   parameter int               DWELL       = 64,
   parameter logic [PH_W-1:0]  CAPTURE_TH  = PLL_CAPTURE_TH,
   parameter int               CAPTURE_CNT = 8,
   parameter logic [PH_W-1:0]  LOCK_TH     = PLL_LOCK_TH,
   parameter int               LOCK_CNT    = 256,
   parameter logic [PH_W-1:0]  UNLOCK_TH   = PLL_UNLOCK_TH,
   parameter int               UNLOCK_CNT  = 4,
   parameter int               KP_SHIFT    = 4,
   parameter int               KI_SHIFT    = 10
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   enable,
   input  logic signed [PH_W-1:0] phase_in,
   input  logic                   phase_valid,
   output logic [FTW_W-1:0]       ftw_out,
   output logic                   ftw_valid,
   output logic [1:0]             state_out,
   output logic                   locked,
   output logic                   sweep_wrap
);

   localparam int DW = $clog2(DWELL + 1);
   localparam int CW = $clog2(CAPTURE_CNT + 1);
   localparam int LW = $clog2(LOCK_CNT + 1);
   localparam int UW = $clog2(UNLOCK_CNT + 1);
   localparam logic [DW-1:0] DWELL_V  = DW'(DWELL);
   localparam logic [CW-1:0] CAP_V    = CW'(CAPTURE_CNT);
   localparam logic [LW-1:0] LOCK_V   = LW'(LOCK_CNT);
   localparam logic [UW-1:0] UNLOCK_V = UW'(UNLOCK_CNT);

   pll_state_t       state_q, state_n;
   logic [DW-1:0]    dwell_q, dwell_n;
   logic [CW-1:0]    cap_q, cap_n;
   logic [LW-1:0]    lock_q, lock_n;
   logic [UW-1:0]    unlock_q, unlock_n;
   logic [FTW_W-1:0] ftw_n, ftw_pi;
   logic             ftw_valid_n, wrap_n;
   logic             pi_clear, pi_load, pi_update;
   logic [PH_W-1:0]  mag;
   logic [FTW_W:0]   step_sum;

   assign mag       = abs_phase(phase_in);
   assign step_sum  = {1'b0, ftw_out} + {1'b0, SWEEP_STEP};
   assign state_out = state_q;
   assign locked    = (state_q == ST_LOCKED);

   pll_pi_filter #(
      .FTW_MIN  (SWEEP_START),
      .FTW_MAX  (SWEEP_STOP),
      .KP_SHIFT (KP_SHIFT),
      .KI_SHIFT (KI_SHIFT)
   ) u_pi (
      .clk      (clk),
      .reset    (reset),
      .clear    (pi_clear),
      .load     (pi_load),
      .load_val (ftw_out),
      .update   (pi_update),
      .phase    (phase_in),
      .ftw_pi   (ftw_pi)
   );

   always_comb begin
      state_n     = state_q;
      ftw_n       = ftw_out;
      ftw_valid_n = 1'b0;
      wrap_n      = 1'b0;
      dwell_n     = dwell_q;
      cap_n       = cap_q;
      lock_n      = lock_q;
      unlock_n    = unlock_q;
      pi_clear    = 1'b0;
      pi_load     = 1'b0;
      pi_update   = 1'b0;
      if (!enable) begin
         state_n  = ST_IDLE;
         dwell_n  = '0;
         cap_n    = '0;
         lock_n   = '0;
         unlock_n = '0;
         pi_clear = 1'b1;
      end else begin
         case (state_q)
            ST_IDLE: begin
               state_n     = ST_SWEEP;
               ftw_n       = SWEEP_START;
               ftw_valid_n = 1'b1;
            end
            ST_SWEEP: if (phase_valid) begin
               cap_n = (mag < CAPTURE_TH) ? cap_q + 1'b1 : '0;
               // A capture on this sample suppresses any dwell step it would also cause
               if (cap_n == CAP_V) begin
                  state_n = ST_ACQUIRE;
                  pi_load = 1'b1;
                  cap_n   = '0;
                  dwell_n = '0;
                  lock_n  = '0;
               end else begin
                  dwell_n = dwell_q + 1'b1;
                  if (dwell_n == DWELL_V) begin
                     dwell_n     = '0;
                     ftw_valid_n = 1'b1;
                     if (step_sum > {1'b0, SWEEP_STOP}) begin
                        ftw_n  = SWEEP_START;
                        wrap_n = 1'b1;
                     end else begin
                        ftw_n = step_sum[FTW_W-1:0];
                     end
                  end
               end
            end
            ST_ACQUIRE: if (phase_valid) begin
               pi_update   = 1'b1;
               ftw_n       = ftw_pi;
               ftw_valid_n = 1'b1;
               lock_n      = (mag <= LOCK_TH) ? lock_q + 1'b1 : '0;
               if (lock_n == LOCK_V) begin
                  state_n  = ST_LOCKED;
                  lock_n   = '0;
                  unlock_n = '0;
               end
            end
            ST_LOCKED: if (phase_valid) begin
               pi_update   = 1'b1;
               ftw_n       = ftw_pi;
               ftw_valid_n = 1'b1;
               unlock_n    = (mag > UNLOCK_TH) ? unlock_q + 1'b1 : '0;
               if (unlock_n == UNLOCK_V) begin
                  state_n   = ST_SWEEP;
                  ftw_n     = SWEEP_START;
                  pi_clear  = 1'b1;
                  pi_update = 1'b0;
                  unlock_n  = '0;
                  dwell_n   = '0;
                  cap_n     = '0;
               end
            end
            default: state_n = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= ST_IDLE;
         ftw_out    <= SWEEP_START;
         ftw_valid  <= 1'b0;
         sweep_wrap <= 1'b0;
         dwell_q    <= '0;
         cap_q      <= '0;
         lock_q     <= '0;
         unlock_q   <= '0;
      end else begin
         state_q    <= state_n;
         ftw_out    <= ftw_n;
         ftw_valid  <= ftw_valid_n;
         sweep_wrap <= wrap_n;
         dwell_q    <= dwell_n;
         cap_q      <= cap_n;
         lock_q     <= lock_n;
         unlock_q   <= unlock_n;
      end
   end

endmodule

// File: tb/tb_pll_loop_ctrl.sv
// tb/tb_pll_loop_ctrl.sv - scoreboard bench for pll_loop_ctrl with directed phase vectors
module tb_pll_loop_ctrl;

   localparam longint START = 64'h28F5C28F;
   localparam longint STOP  = 64'h2B851EB8;
   localparam longint STEP  = 64'h00010000;

   logic               clk = 1'b0;
   logic               reset = 1'b0;
   logic               enable = 1'b0;
   logic               phase_valid = 1'b0;
   logic signed [15:0] phase_in = '0;
   logic [31:0]        ftw_out;
   logic               ftw_valid;
   logic [1:0]         state_out;
   logic               locked;
   logic               sweep_wrap;

   typedef struct {
      logic [31:0] ftw;
      logic        wrap;
      int unsigned cyc;
   } exp_t;

   exp_t        exp_q[$];
   exp_t        mon_e;
   int          n_checks = 0;
   int          n_fail = 0;
   int          n_wraps = 0;
   int unsigned cyc = 0;

   longint m_ftw = START;
   longint m_integ = 0;
   int     m_dwell = 0;
   int     m_cap = 0;
   bit     m_wrapped = 0;

   pll_loop_ctrl dut (
      .clk         (clk),
      .reset       (reset),
      .enable      (enable),
      .phase_in    (phase_in),
      .phase_valid (phase_valid),
      .ftw_out     (ftw_out),
      .ftw_valid   (ftw_valid),
      .state_out   (state_out),
      .locked      (locked),
      .sweep_wrap  (sweep_wrap)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "watchdog");
   end

   // Monitor: every ftw_valid pulse is matched against the oldest expectation
   always @(negedge clk) begin
      if (sweep_wrap) n_wraps++;
      if (ftw_valid) begin
         n_checks++;
         if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL ftw_unexpected: ftw_out=0x%08h wrap=%0b cycle=%0d, required no update", ftw_out, sweep_wrap, cyc);
         end else begin
            mon_e = exp_q.pop_front();
            if (ftw_out !== mon_e.ftw || sweep_wrap !== mon_e.wrap || cyc != mon_e.cyc) begin
               n_fail++;
               $display("FAIL ftw_update: ftw_out=0x%08h wrap=%0b cycle=%0d, required 0x%08h wrap=%0b cycle=%0d",
                        ftw_out, sweep_wrap, cyc, mon_e.ftw, mon_e.wrap, mon_e.cyc);
            end
         end
      end else if (sweep_wrap) begin
         n_checks++;
         n_fail++;
         $display("FAIL wrap_without_valid: sweep_wrap=1 ftw_valid=0 at cycle %0d", cyc);
      end
   end

   task automatic check(input string name, input longint act, input longint exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
      end
   endtask

   task automatic idle(input int n);
      repeat (n) begin @(posedge clk); #1; end
   endtask

   task automatic push(input longint f, input logic w);
      exp_t e;
      e.ftw  = f[31:0];
      e.wrap = w;
      e.cyc  = cyc + 1;
      exp_q.push_back(e);
   endtask

   task automatic strobe(input int p, input int gap);
      phase_in    = 16'(p);
      phase_valid = 1'b1;
      @(posedge clk); #1;
      phase_valid = 1'b0;
      repeat (gap) begin @(posedge clk); #1; end
   endtask

   function automatic longint clampl(input longint v);
      if (v < START) return START;
      if (v > STOP) return STOP;
      return v;
   endfunction

   task automatic sweep_sample(input int p, input int gap);
      int     mag;
      longint nxt;
      mag = (p < 0) ? -p : p;
      m_cap = (mag < 3000) ? m_cap + 1 : 0;
      if (m_cap == 8) begin
         m_integ = m_ftw;
         m_cap   = 0;
         m_dwell = 0;
      end else begin
         m_dwell++;
         if (m_dwell == 64) begin
            m_dwell = 0;
            nxt = m_ftw + STEP;
            if (nxt > STOP) begin
               m_ftw = START;
               m_wrapped = 1;
               push(m_ftw, 1'b1);
            end else begin
               m_ftw = nxt;
               push(m_ftw, 1'b0);
            end
         end
      end
      strobe(p, gap);
   endtask

   task automatic pi_sample(input int p, input int gap);
      longint pl;
      pl = p;
      m_integ = clampl(m_integ + (pl >>> 10));
      m_ftw   = clampl(m_integ + (pl >>> 4));
      push(m_ftw, 1'b0);
      strobe(p, gap);
   endtask

   task automatic enable_on();
      push(START, 1'b0);
      enable = 1'b1;
      @(posedge clk); #1;
      m_ftw = START; m_dwell = 0; m_cap = 0;
   endtask

   task automatic capture();
      for (int i = 0; i < 8; i++) sweep_sample(1000, 0);
   endtask

   initial begin
      // Reset values
      idle(3);
      check("reset_state", longint'(state_out), 0);
      check("reset_ftw", longint'(ftw_out), START);
      check("reset_locked", longint'(locked), 0);
      check("reset_valid", longint'(ftw_valid), 0);
      reset = 1'b1;
      idle(2);
      check("idle_hold_state", longint'(state_out), 0);

      // Coarse sweep up to the ceiling and the single wrap back to START
      enable_on();
      check("sweep_state", longint'(state_out), 1);
      for (int i = 0; i < 50000 && !m_wrapped; i++)
         sweep_sample(9000, (i < 128) ? 2 : 0);
      idle(2);
      check("wrap_count", n_wraps, 1);
      check("wrap_ftw", longint'(ftw_out), START);
      check("wrap_state", longint'(state_out), 1);

      // Capture, then first PI update: integ + 1 + 64
      for (int i = 0; i < 64; i++) sweep_sample(9000, 0);
      capture();
      check("acq_state", longint'(state_out), 2);
      check("acq_ftw_hold", longint'(ftw_out), START + STEP);
      pi_sample(1024, 1);
      check("pi_first", longint'(ftw_out), START + STEP + 65);

      // Lock counting with a break at 600
      for (int i = 0; i < 255; i++) pi_sample((i % 2) ? -400 : 400, 0);
      check("acq_255", longint'(state_out), 2);
      pi_sample(600, 0);
      for (int i = 0; i < 255; i++) pi_sample((i % 2) ? -400 : 400, 0);
      check("acq_restart_255", longint'(state_out), 2);
      pi_sample(400, 0);
      check("lock_state", longint'(state_out), 3);
      check("lock_flag", longint'(locked), 1);

      // Unlock: three outliers then a clean sample hold lock; four drop it
      for (int i = 0; i < 3; i++) pi_sample(2500, 0);
      pi_sample(0, 0);
      check("lock_hold", longint'(state_out), 3);
      for (int i = 0; i < 3; i++) pi_sample(2500, 0);
      push(START, 1'b0);
      m_ftw = START; m_integ = 0; m_dwell = 0; m_cap = 0;
      strobe(2500, 1);
      check("unlock_state", longint'(state_out), 1);
      check("unlock_locked", longint'(locked), 0);
      check("unlock_ftw", longint'(ftw_out), START);

      // Asynchronous reset in LOCKED
      capture();
      for (int i = 0; i < 256; i++) pi_sample(0, 0);
      pi_sample(1600, 2);
      check("pre_reset_locked", longint'(state_out), 3);
      check("pre_reset_ftw", longint'(ftw_out), START + 101);
      @(posedge clk); #2;
      reset = 1'b0;
      enable = 1'b0;
      #1;
      check("async_state", longint'(state_out), 0);
      check("async_ftw", longint'(ftw_out), START);
      check("async_locked", longint'(locked), 0);
      idle(3);
      reset = 1'b1;
      idle(1);
      check("release_state", longint'(state_out), 0);
      check("release_ftw", longint'(ftw_out), START);

      // Saturation at the floor, then disable
      enable_on();
      capture();
      check("sat_acq", longint'(state_out), 2);
      m_integ = START;
      for (int i = 0; i < 5; i++) pi_sample(-32768, 0);
      check("sat_ftw", longint'(ftw_out), START);
      enable = 1'b0;
      @(posedge clk); #1;
      check("disable_state", longint'(state_out), 0);
      check("disable_ftw", longint'(ftw_out), START);

      idle(3);
      check("scoreboard_drain", exp_q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
